// File: rtl/axi_s2mm_ring_pkg.sv
// Shared types and space-accounting helpers for the S2MM ring-buffer controller.
package axi_s2mm_ring_pkg;

  localparam int unsigned OFF_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_TRIGGER,
    ST_XFER,
    ST_UPDATE,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic ok;
    logic wrap;
  } fit_t;

  // Round (byte count - 1) up to whole beats; b must be a power of two.
  function automatic logic [OFF_W-1:0] align_up(input logic [15:0] len, input int unsigned b);
    return (OFF_W'(len) | OFF_W'(b - 1)) + OFF_W'(1);
  endfunction

  // Placement decision; one beat of gap is kept so full never looks empty.
  function automatic fit_t fits(input logic [OFF_W-1:0] wr, input logic [OFF_W-1:0] rd,
                                input logic [OFF_W-1:0] s, input logic [OFF_W-1:0] l);
    fit_t f;
    f = '0;
    if (wr >= rd) begin
      if ((l <= s - wr) && !((wr + l == s) && (rd == '0))) begin
        f.ok = 1'b1;
      end else if (l < rd) begin
        f.ok   = 1'b1;
        f.wrap = 1'b1;
      end
    end else if (l < rd - wr) begin
      f.ok = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/axi_s2mm_ring_ctrl.sv
// Places length-prefixed packets into a circular memory buffer via the S2MM engine,
// dropping packets that do not fit and publishing the write pointer to software.
module axi_s2mm_ring_ctrl
  import axi_s2mm_ring_pkg::*;
#(
  parameter int unsigned C_AXI_WIDTH      = 128,
  parameter int unsigned C_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_PTR_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   buf_base,
  input  logic [C_PTR_WIDTH-1:0]        buf_size,
  input  logic [C_PTR_WIDTH-1:0]        rd_ptr,
  output logic [C_PTR_WIDTH-1:0]        wr_ptr,
  input  logic [15:0]                   s_axis_len_tdata,
  input  logic                          s_axis_len_tvalid,
  output logic                          s_axis_len_tready,
  input  logic [C_AXI_WIDTH-1:0]        s_axis_tdata,
  input  logic [C_AXI_WIDTH/8-1:0]      s_axis_tstrb,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXI_WIDTH-1:0]        m_axis_tdata,
  output logic [C_AXI_WIDTH/8-1:0]      m_axis_tstrb,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          dma_trigger,
  output logic [C_AXI_ADDR_WIDTH-1:0]   dma_start_addr,
  output logic [15:0]                   dma_bytes_to_write,
  input  logic                          dma_busy,
  input  logic [1:0]                    dma_response,
  output logic                          pkt_done,
  output logic [31:0]                   drop_count,
  output logic                          err
);

  localparam int unsigned B = C_AXI_WIDTH / 8;

  state_e                        state_q, state_d;
  logic [15:0]                   len_q, len_d;
  logic [C_PTR_WIDTH-1:0]        start_off_q, start_off_d;
  logic                          fwd_en_q, fwd_en_d;
  logic                          busy_seen_q, busy_seen_d;
  logic [C_PTR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic                          dma_trigger_q, dma_trigger_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   dma_addr_q, dma_addr_d;
  logic [15:0]                   dma_bytes_q, dma_bytes_d;
  logic                          pkt_done_q, pkt_done_d;
  logic [31:0]                   drop_count_q, drop_count_d;
  logic                          err_q, err_d;

  logic [OFF_W-1:0]              len_al;
  logic [OFF_W-1:0]              end_off;
  logic [C_PTR_WIDTH-1:0]        start_sel;
  fit_t                          fit;

  assign len_al    = align_up(len_q, B);
  assign fit       = fits(OFF_W'(wr_ptr_q), OFF_W'(rd_ptr), OFF_W'(buf_size), len_al);
  assign start_sel = fit.wrap ? '0 : wr_ptr_q;
  assign end_off   = OFF_W'(start_off_q) + len_al;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      start_off_q   <= '0;
      fwd_en_q      <= 1'b0;
      busy_seen_q   <= 1'b0;
      wr_ptr_q      <= '0;
      dma_trigger_q <= 1'b0;
      dma_addr_q    <= '0;
      dma_bytes_q   <= '0;
      pkt_done_q    <= 1'b0;
      drop_count_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      start_off_q   <= start_off_d;
      fwd_en_q      <= fwd_en_d;
      busy_seen_q   <= busy_seen_d;
      wr_ptr_q      <= wr_ptr_d;
      dma_trigger_q <= dma_trigger_d;
      dma_addr_q    <= dma_addr_d;
      dma_bytes_q   <= dma_bytes_d;
      pkt_done_q    <= pkt_done_d;
      drop_count_q  <= drop_count_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    start_off_d       = start_off_q;
    fwd_en_d          = fwd_en_q;
    busy_seen_d       = busy_seen_q;
    wr_ptr_d          = wr_ptr_q;
    dma_trigger_d     = 1'b0;
    dma_addr_d        = dma_addr_q;
    dma_bytes_d       = dma_bytes_q;
    pkt_done_d        = 1'b0;
    drop_count_d      = drop_count_q;
    err_d             = err_q;
    s_axis_len_tready = 1'b0;
    s_axis_tready     = 1'b0;
    m_axis_tvalid     = 1'b0;
    m_axis_tdata      = '0;
    m_axis_tstrb      = '0;
    m_axis_tlast      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_axis_len_tready = enable & ~rst;
        if (enable && s_axis_len_tvalid) begin
          len_d   = s_axis_len_tdata;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fit.ok) begin
          start_off_d = start_sel;
          dma_addr_d  = buf_base + C_AXI_ADDR_WIDTH'(start_sel);
          dma_bytes_d = len_q;
          state_d     = ST_TRIGGER;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_TRIGGER: begin
        if (!dma_busy) begin
          dma_trigger_d = 1'b1;
          fwd_en_d      = 1'b1;
          busy_seen_d   = 1'b0;
          state_d       = ST_XFER;
        end
      end
      ST_XFER: begin
        s_axis_tready = m_axis_tready & fwd_en_q;
        m_axis_tvalid = s_axis_tvalid & fwd_en_q;
        if (fwd_en_q) begin
          m_axis_tdata = s_axis_tdata;
          m_axis_tstrb = s_axis_tstrb;
          m_axis_tlast = s_axis_tlast;
        end
        if (s_axis_tvalid && m_axis_tready && fwd_en_q && s_axis_tlast) fwd_en_d = 1'b0;
        if (dma_busy) busy_seen_d = 1'b1;
        // Commit on exit so the registered results are visible during UPDATE.
        if (busy_seen_q && !dma_busy && !fwd_en_q) begin
          wr_ptr_d   = (end_off == OFF_W'(buf_size)) ? '0 : C_PTR_WIDTH'(end_off);
          pkt_done_d = 1'b1;
          err_d      = err_q | (dma_response >= 2'd2);
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          if (drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_ptr             = wr_ptr_q;
  assign dma_trigger        = dma_trigger_q;
  assign dma_start_addr     = dma_addr_q;
  assign dma_bytes_to_write = dma_bytes_q;
  assign pkt_done           = pkt_done_q;
  assign drop_count         = drop_count_q;
  assign err                = err_q;

endmodule

// File: tb/tb_axi_s2mm_ring_ctrl.sv
// Self-checking bench: directed ring scenarios plus random packets against a ring-space model.
module tb_axi_s2mm_ring_ctrl;

  localparam logic [31:0] S    = 32'h1000;
  localparam logic [63:0] BASE = 64'h1000_0000;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [63:0]   buf_base;
  logic [31:0]   buf_size;
  logic [31:0]   rd_ptr;
  logic [31:0]   wr_ptr;
  logic [15:0]   s_axis_len_tdata;
  logic          s_axis_len_tvalid;
  logic          s_axis_len_tready;
  logic [127:0]  s_axis_tdata;
  logic [15:0]   s_axis_tstrb;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [127:0]  m_axis_tdata;
  logic [15:0]   m_axis_tstrb;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          dma_trigger;
  logic [63:0]   dma_start_addr;
  logic [15:0]   dma_bytes_to_write;
  logic          dma_busy;
  logic [1:0]    dma_response;
  logic          pkt_done;
  logic [31:0]   drop_count;
  logic          err;

  axi_s2mm_ring_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .buf_base(buf_base), .buf_size(buf_size),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
    .s_axis_len_tdata(s_axis_len_tdata), .s_axis_len_tvalid(s_axis_len_tvalid),
    .s_axis_len_tready(s_axis_len_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .dma_trigger(dma_trigger), .dma_start_addr(dma_start_addr),
    .dma_bytes_to_write(dma_bytes_to_write), .dma_busy(dma_busy),
    .dma_response(dma_response), .pkt_done(pkt_done), .drop_count(drop_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_pass, n_total;
  int unsigned   trig_cnt, done_cnt, mv_cnt;
  logic          m_last_seen;
  logic [63:0]   cap_addr;
  logic [15:0]   cap_bytes;
  time           len_t, trig_t;
  logic [143:0]  tx_q[$];
  logic [143:0]  rx_q[$];
  logic [31:0]   exp_wr, exp_drop;
  logic          exp_err;
  logic [1:0]    resp_cfg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, where handshakes are stable.
  always @(negedge clk) begin
    if (dma_trigger === 1'b1) begin
      trig_cnt++;
      cap_addr  = dma_start_addr;
      cap_bytes = dma_bytes_to_write;
      trig_t    = $time;
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      rx_q.push_back({m_axis_tstrb, m_axis_tdata});
      if (m_axis_tlast) m_last_seen = 1'b1;
    end
    if (m_axis_tvalid === 1'b1) mv_cnt++;
    if (pkt_done === 1'b1) done_cnt++;
  end

  // Sink backpressure.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      tick();
      m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Engine model: busy after trigger until the last beat lands, then a response.
  initial begin
    dma_busy = 1'b0;
    dma_response = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst && dma_trigger === 1'b1) begin
        tick();
        dma_busy = 1'b1;
        dma_response = 2'd0;
        for (int i = 0; i < 3000; i++) begin
          tick();
          if (m_last_seen || rst) break;
        end
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) if (!rst) tick();
        dma_busy = 1'b0;
        dma_response = rst ? 2'd0 : resp_cfg;
      end else if (rst) begin
        dma_busy = 1'b0;
        dma_response = 2'd0;
      end
    end
  end

  task automatic send_desc(input logic [15:0] len, output logic got);
    got = 1'b0;
    s_axis_len_tdata  = len;
    s_axis_len_tvalid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = s_axis_len_tvalid & s_axis_len_tready;
      if (got) len_t = $time;
      tick();
    end
    s_axis_len_tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic last, output logic got);
    logic [127:0] d;
    logic [15:0]  st;
    if ($urandom_range(0, 3) == 0) tick();
    d  = {$urandom, $urandom, $urandom, $urandom};
    st = last ? (16'hFFFF >> $urandom_range(0, 15)) : 16'hFFFF;
    s_axis_tdata  = d;
    s_axis_tstrb  = st;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = s_axis_tvalid & s_axis_tready;
      tick();
    end
    s_axis_tvalid = 1'b0;
    tx_q.push_back({st, d});
  endtask

  // One packet end to end, predicted from ring occupancy arithmetic.
  task automatic run_pkt(input logic [15:0] len, input logic [31:0] rd, input logic [1:0] resp,
                         input logic chk_lat);
    longint unsigned l, wr, r, off;
    int unsigned     nb, trig0, done0, mv0;
    logic            here, wrap, fit, got, all_got, data_ok;
    l  = ((longint'(len) / 16) + 1) * 16;
    wr = longint'(exp_wr);
    r  = longint'(rd);
    if (wr >= r) begin
      here = (l <= longint'(S) - wr) && (((wr + l) % longint'(S)) != r);
      wrap = !here && (l < r);
    end else begin
      here = (l < r - wr);
      wrap = 1'b0;
    end
    fit = here | wrap;
    off = wrap ? 0 : wr;
    nb  = int'(len) / 16 + 1;

    rd_ptr = rd;
    resp_cfg = resp;
    trig0 = trig_cnt;
    done0 = done_cnt;
    mv0   = mv_cnt;
    tx_q.delete();
    rx_q.delete();
    m_last_seen = 1'b0;

    send_desc(len, got);
    check("len_handshake", 64'(got), 64'd1);
    all_got = 1'b1;
    for (int b = 0; b < int'(nb); b++) begin
      send_beat(b == int'(nb) - 1, got);
      all_got &= got;
    end
    check("beats_accepted", 64'(all_got), 64'd1);
    if (fit) begin
      for (int i = 0; i < 500 && done_cnt == done0; i++) tick();
    end
    tick();
    tick();

    if (fit) begin
      exp_wr = ((off + l) == longint'(S)) ? 32'd0 : 32'(off + l);
      if (resp >= 2'd2) exp_err = 1'b1;
    end else if (exp_drop != 32'hFFFF_FFFF) begin
      exp_drop = exp_drop + 32'd1;
    end

    check("trigger_count", 64'(trig_cnt - trig0), fit ? 64'd1 : 64'd0);
    check("pkt_done_count", 64'(done_cnt - done0), fit ? 64'd1 : 64'd0);
    check("wr_ptr", 64'(wr_ptr), 64'(exp_wr));
    check("drop_count", 64'(drop_count), 64'(exp_drop));
    check("err", 64'(err), 64'(exp_err));
    if (fit) begin
      data_ok = (rx_q.size() == tx_q.size());
      for (int i = 0; i < rx_q.size() && data_ok; i++) data_ok = (rx_q[i] === tx_q[i]);
      check("start_addr", cap_addr, BASE + 64'(off));
      check("bytes_to_write", 64'(cap_bytes), 64'(len));
      check("fwd_data", 64'(data_ok), 64'd1);
      if (chk_lat) check("desc_to_trigger", 64'((trig_t - len_t) / 10), 64'd3);
    end else begin
      check("drop_no_mvalid", 64'(mv_cnt - mv0), 64'd0);
    end
  endtask

  initial begin
    logic got;
    n_pass = 0; n_total = 0;
    trig_cnt = 0; done_cnt = 0; mv_cnt = 0;
    m_last_seen = 1'b0;
    cap_addr = '0; cap_bytes = '0; len_t = 0; trig_t = 0;
    exp_wr = '0; exp_drop = '0; exp_err = 1'b0; resp_cfg = 2'd1;
    rst = 1'b1; enable = 1'b1; buf_base = BASE; buf_size = S; rd_ptr = '0;
    s_axis_len_tdata = '0; s_axis_len_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;

    tick();
    tick();
    check("reset_outputs", 64'(|{wr_ptr, dma_trigger, dma_start_addr, dma_bytes_to_write,
                                  pkt_done, drop_count, err, s_axis_len_tready, s_axis_tready,
                                  m_axis_tvalid}), 64'd0);
    rst = 1'b0;
    tick();

    run_pkt(16'd99,    32'h000, 2'd1, 1'b1);
    run_pkt(16'hF4F,   32'h000, 2'd1, 1'b0);
    run_pkt(16'd127,   32'h200, 2'd1, 1'b0);
    run_pkt(16'd127,   32'h200, 2'd1, 1'b0);
    run_pkt(16'd127,   32'h180, 2'd1, 1'b0);
    run_pkt(16'hE7F,   32'h100, 2'd1, 1'b0);
    run_pkt(16'd127,   32'h000, 2'd1, 1'b0);
    run_pkt(16'd127,   32'h010, 2'd1, 1'b0);
    run_pkt(16'd31,    32'h000, 2'd2, 1'b0);
    run_pkt(16'd31,    32'h000, 2'd1, 1'b0);

    // Descriptor must be refused while disabled.
    enable = 1'b0;
    s_axis_len_tdata = 16'd15;
    s_axis_len_tvalid = 1'b1;
    begin
      int unsigned t0;
      t0 = trig_cnt;
      for (int i = 0; i < 5; i++) tick();
      check("disabled_len_tready", 64'(s_axis_len_tready), 64'd0);
      check("disabled_no_trigger", 64'(trig_cnt - t0), 64'd0);
    end
    s_axis_len_tvalid = 1'b0;
    enable = 1'b1;
    tick();

    for (int k = 0; k < 24; k++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'd1;
      run_pkt(16'($urandom_range(0, 16'h17F)), 32'($urandom_range(0, 255)) << 4, rsp, 1'b0);
    end

    // Asynchronous reset in the middle of a transfer.
    rd_ptr = 32'h0;
    if (exp_wr != 32'h0) rd_ptr = exp_wr - 32'h10;
    m_last_seen = 1'b0;
    resp_cfg = 2'd1;
    begin
      int unsigned t0;
      t0 = trig_cnt;
      send_desc(16'd63, got);
      check("midrst_len_handshake", 64'(got), 64'd1);
      s_axis_tdata = {4{$urandom}};
      s_axis_tstrb = 16'hFFFF;
      s_axis_tlast = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 100 && trig_cnt == t0; i++) tick();
      check("midrst_triggered", 64'(trig_cnt - t0), 64'd1);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'(|{wr_ptr, dma_trigger, dma_start_addr, dma_bytes_to_write,
                                       pkt_done, drop_count, err, s_axis_len_tready,
                                       s_axis_tready, m_axis_tvalid}), 64'd0);
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    exp_wr = '0; exp_drop = '0; exp_err = 1'b0;
    tick();
    run_pkt(16'd99, 32'h000, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
